fetch_stage: RTL

Instruction fetch stage that feeds the main control decoder.
- Owns the program counter and issues word fetches to instruction memory over a req/gnt/rvalid handshake.
- Buffers each returned instruction in an IF/ID register and presents it to decode over a valid/ready handshake.
- Exposes the opcode field directly, so the decoder's op input connects to id_op.
- Accepts PC redirects from branch/jump resolution and flushes wrong-path instructions.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_stage_if_id.sv | 36 +++
 rtl/fetch_stage.sv | 83 ++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, NOP and opcode constants for fetch and decode
package fetch_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
endpackage

// File: rtl/fetch_stage_if_id.sv
// if_id_reg: IF/ID pipeline register with valid/ready, load/consume/flush and PC+4
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [31:0]     next_instr,
  input  logic [XLEN-1:0] next_pc,
  output logic            valid,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcplus4
);
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      instr   <= NOP_INSTR;
      pc      <= '0;
      pcplus4 <= '0;
    end else if (load && !flush) begin
      valid   <= 1'b1;
      instr   <= next_instr;
      pc      <= next_pc;
      pcplus4 <= next_pc + XLEN'(4);
    end else if (flush || ready) begin
      valid   <= 1'b0;
    end
  end
  assign op = instr[6:0];
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing single-outstanding imem fetches into an IF/ID register
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [6:0]      id_op,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pcplus4
);
  state_t          state, state_n;
  logic [XLEN-1:0] pc, req_pc, hold_pc;
  logic [31:0]     hold_instr;
  logic            drop, free, grant, resp, load;
  assign free  = !id_valid || id_ready;
  assign grant = state == REQ && imem_gnt;
  assign resp  = state == WAIT && imem_rvalid;
  assign load  = !redirect && ((resp && !drop && free) || (state == HOLD && free));
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = REQ;
      REQ:     state_n = imem_gnt ? WAIT : REQ;
      WAIT:    state_n = !imem_rvalid ? WAIT : (redirect || drop || free) ? REQ : HOLD;
      HOLD:    state_n = (redirect || free) ? REQ : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    imem_req  = state == REQ;
    imem_addr = pc;
  end
  // drop marks an in-flight request that a redirect turned into wrong-path work
  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      req_pc     <= '0;
      drop       <= 1'b0;
      hold_instr <= '0;
      hold_pc    <= '0;
    end else begin
      if (grant) req_pc <= pc;
      if (redirect) pc <= {redirect_pc[XLEN-1:2], 2'b00};
      else if (grant) pc <= pc + XLEN'(4);
      drop <= redirect ? (grant || (state == WAIT && !imem_rvalid)) : (resp ? 1'b0 : drop);
      if (resp && !drop && !free) begin
        hold_instr <= imem_rdata;
        hold_pc    <= req_pc;
      end
    end
  end
  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .flush      (redirect),
    .ready      (id_ready),
    .next_instr (resp ? imem_rdata : hold_instr),
    .next_pc    (resp ? req_pc : hold_pc),
    .valid      (id_valid),
    .instr      (id_instr),
    .op         (id_op),
    .pc         (id_pc),
    .pcplus4    (id_pcplus4)
  );
endmodule
